// File: rtl/mux4_to_1_rr_pkg.sv
// Shared definitions for the 4-to-1 round-robin packet multiplexer.
// Holds the channel count, the source-select width and the FSM state encoding.
package mux4_to_1_rr_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/mux4_to_1_rr_if.sv
// Bus bundle for mux4_to_1_rr: four source channels merged onto one sink.
//   in_data   : channel i occupies bits [i*DATA_W +: DATA_W]
//   in_valid  : per-channel beat valid
//   in_last   : per-channel end-of-packet marker (qualified by in_valid)
//   in_ready  : per-channel accept, one-hot or zero
//   out_data  : registered output beat
//   out_sel   : source channel index of out_data
//   out_last  : end-of-packet marker of the output beat
//   out_valid : output beat valid
//   out_ready : sink accept
// master drives sources and sink-ready (testbench / surrounding logic),
// slave is the multiplexer itself.
interface mux4_to_1_rr_if
    import mux4_to_1_rr_pkg::*;
#(
    parameter int DATA_W = 8
);

    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_last;
    logic [NUM_CH-1:0]        in_ready;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_sel;
    logic                     out_last;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_sel, out_last, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_sel, out_last, out_valid
    );

endinterface

// File: rtl/mux4_to_1_rr_rr_arbiter4.sv
// rr_arbiter4: combinational rotating-priority search over four requesters.
// The search starts at the channel after i_last_grant and wraps around, so the
// most recently granted channel has lowest priority.
//   i_req         : request vector
//   i_last_grant  : channel granted most recently
//   o_grant       : first requesting channel in rotated order
//   o_grant_valid : at least one request present
module rr_arbiter4
    import mux4_to_1_rr_pkg::*;
(
    input  logic [NUM_CH-1:0] i_req,
    input  logic [SEL_W-1:0]  i_last_grant,
    output logic [SEL_W-1:0]  o_grant,
    output logic              o_grant_valid
);

    logic             w_found;
    logic [SEL_W-1:0] w_idx;

    always_comb begin
        o_grant       = i_last_grant;
        o_grant_valid = |i_req;
        w_found       = 1'b0;
        w_idx         = '0;
        // Offset NUM_CH wraps to i_last_grant itself, which is searched last.
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            w_idx = i_last_grant + SEL_W'(k);
            if (!w_found && i_req[w_idx]) begin
                o_grant = w_idx;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_to_1_rr.sv
// mux4_to_1_rr: merges four valid/ready packet sources onto one registered
// output. Sources are arbitrated round-robin per packet; once a multi-beat
// packet starts, the grant is locked to that source until its last beat, so
// packets never interleave.
//   clk   : system clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mux4_to_1_rr_if (sources in, sink out)
module mux4_to_1_rr
    import mux4_to_1_rr_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    mux4_to_1_rr_if.slave      bus
);

    state_t             r_state;
    logic [SEL_W-1:0]   r_lock_idx;
    logic [SEL_W-1:0]   r_last_grant;
    logic [DATA_W-1:0]  r_out_data;
    logic [SEL_W-1:0]   r_out_sel;
    logic               r_out_last;
    logic               r_out_valid;

    logic [SEL_W-1:0]   w_arb_grant;
    logic               w_arb_valid;
    logic [SEL_W-1:0]   w_grant;
    logic               w_grant_valid;
    logic               w_load;
    logic               w_accept;
    logic [DATA_W-1:0]  w_beat_data;
    logic               w_beat_last;
    logic [NUM_CH-1:0]  w_in_ready;

    rr_arbiter4 u_arb (
        .i_req         (bus.in_valid),
        .i_last_grant  (r_last_grant),
        .o_grant       (w_arb_grant),
        .o_grant_valid (w_arb_valid)
    );

    // Output register can take a beat when empty or draining this cycle.
    assign w_load = !r_out_valid || bus.out_ready;

    // While locked, only the owning source may pass; its valid gaps become bubbles.
    assign w_grant       = (r_state == ST_LOCKED) ? r_lock_idx : w_arb_grant;
    assign w_grant_valid = (r_state == ST_LOCKED) ? bus.in_valid[r_lock_idx] : w_arb_valid;
    assign w_accept      = w_load && w_grant_valid;

    assign w_beat_data = bus.in_data[w_grant*DATA_W +: DATA_W];
    assign w_beat_last = bus.in_last[w_grant];

    always_comb begin
        w_in_ready = '0;
        if (w_accept) begin
            w_in_ready[w_grant] = 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;
    assign bus.out_last  = r_out_last;
    assign bus.out_valid = r_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_lock_idx   <= '0;
            r_last_grant <= SEL_W'(NUM_CH - 1);
            r_out_data   <= '0;
            r_out_sel    <= '0;
            r_out_last   <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_data  <= w_beat_data;
                r_out_sel   <= w_grant;
                r_out_last  <= w_beat_last;
                r_out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_last_grant <= w_grant;
                        if (!w_beat_last) begin
                            r_state    <= ST_LOCKED;
                            r_lock_idx <= w_grant;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_accept && w_beat_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_to_1_rr.sv
// Self-checking bench for mux4_to_1_rr. Per-channel source queues feed the
// DUT; an independent reference model predicts in_ready each cycle and pushes
// the expected output beat into a scoreboard queue, which is compared against
// out_* while out_valid is high and popped on each sink handshake.
module tb_mux4_to_1_rr;
    import mux4_to_1_rr_pkg::*;

    localparam int DW = 8;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] s;
        logic       l;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux4_to_1_rr_if #(.DATA_W(DW)) bus ();

    mux4_to_1_rr #(.DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] src_q [4][$];   // {last, data}
    logic [3:0] src_en;
    logic       want_ready;
    logic [3:0] acc;

    exp_t       exp_q [$];
    logic [1:0] sel_log [$];

    int   m_state;
    int   m_lock;
    int   m_last;
    logic m_ov;

    task automatic model_reset();
        m_state = 0;
        m_lock  = 0;
        m_last  = 3;
        m_ov    = 1'b0;
        exp_q.delete();
        acc     = '0;
    endtask

    task automatic clear_sources();
        for (int ch = 0; ch < 4; ch++) src_q[ch].delete();
        bus.in_valid = '0;
        bus.in_last  = '0;
    endtask

    task automatic drive_inputs();
        logic [8:0] b;
        for (int ch = 0; ch < 4; ch++) begin
            if (acc[ch] && src_q[ch].size() > 0) void'(src_q[ch].pop_front());
            if (src_en[ch] && src_q[ch].size() > 0) begin
                b = src_q[ch][0];
                bus.in_valid[ch]         = 1'b1;
                bus.in_data[ch*DW +: DW] = b[7:0];
                bus.in_last[ch]          = b[8];
            end else begin
                bus.in_valid[ch] = 1'b0;
                bus.in_last[ch]  = 1'b0;
            end
        end
        bus.out_ready = want_ready;
    endtask

    // Reference model + scoreboard, evaluated mid-cycle when inputs are stable.
    task automatic scoreboard_cycle();
        logic [3:0] exp_rdy;
        logic       gv;
        int         c;
        exp_t       e;
        acc = '0;
        if (!rst_n) return;
        gv = 1'b0;
        c  = 0;
        if (m_state == 0) begin
            for (int k = 1; k <= 4; k++) begin
                if (!gv && bus.in_valid[(m_last + k) % 4]) begin
                    gv = 1'b1;
                    c  = (m_last + k) % 4;
                end
            end
        end else begin
            c  = m_lock;
            gv = bus.in_valid[c];
        end
        exp_rdy = ((!m_ov || bus.out_ready) && gv) ? 4'(1 << c) : 4'b0;

        checks++;
        if (bus.in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL sb_in_ready t=%0t got %b exp %b", $time, bus.in_ready, exp_rdy);
        end
        checks++;
        if (bus.out_valid !== m_ov) begin
            errors++;
            $display("FAIL sb_out_valid t=%0t got %b exp %b", $time, bus.out_valid, m_ov);
        end
        if (m_ov && exp_q.size() > 0) begin
            e = exp_q[0];
            checks++;
            if (bus.out_data !== e.d || bus.out_sel !== e.s || bus.out_last !== e.l) begin
                errors++;
                $display("FAIL sb_beat t=%0t got d=%h s=%0d l=%b exp d=%h s=%0d l=%b",
                         $time, bus.out_data, bus.out_sel, bus.out_last, e.d, e.s, e.l);
            end
        end
        if (m_ov && bus.out_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            sel_log.push_back(bus.out_sel);
        end
        if (exp_rdy != 4'b0) begin
            e.d = bus.in_data[c*DW +: DW];
            e.s = 2'(c);
            e.l = bus.in_last[c];
            exp_q.push_back(e);
            m_ov = 1'b1;
            if (m_state == 0) begin
                m_last = c;
                if (!e.l) begin
                    m_state = 1;
                    m_lock  = c;
                end
            end else if (e.l) begin
                m_state = 0;
            end
        end else if (bus.out_ready) begin
            m_ov = 1'b0;
        end
        acc = bus.in_valid & bus.in_ready;
    endtask

    // Inputs change just after the rising edge; checks run on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        drive_inputs();
        @(negedge clk);
        scoreboard_cycle();
    endtask

    function automatic bit busy();
        bit b = (exp_q.size() > 0);
        for (int ch = 0; ch < 4; ch++) if (src_q[ch].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic drain(input int max_cycles);
        int n = 0;
        while (busy() && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (busy()) begin
            errors++;
            $display("FAIL drain_timeout t=%0t got busy after %0d cycles exp idle", $time, n);
            clear_sources();
            exp_q.delete();
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_sources();
        model_reset();
        repeat (2) tick();
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_sel !== 2'd0 ||
            bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h s=%0d l=%b exp all zero",
                     bus.out_valid, bus.out_data, bus.out_sel, bus.out_last);
        end
        checks++;
        if (bus.in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_in_ready got %b exp 0000", bus.in_ready);
        end
    endtask

    task automatic test_single();
        src_q[2].push_back({1'b1, 8'hA5});
        tick();
        checks++;
        if (bus.in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_in_ready got %b exp 0100", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.out_sel !== 2'd2 ||
            bus.out_last !== 1'b1) begin
            errors++;
            $display("FAIL single_out got v=%b d=%h s=%0d l=%b exp v=1 d=a5 s=2 l=1",
                     bus.out_valid, bus.out_data, bus.out_sel, bus.out_last);
        end
        drain(10);
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int n = 0; n < 2; n++)
            for (int ch = 0; ch < 4; ch++)
                src_q[ch].push_back({1'b1, 8'(8'h20 + ch*16 + n)});
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'(i % 4)) begin
                errors++;
                $display("FAIL rr_seq[%0d] got v=%b s=%0d exp v=1 s=%0d",
                         i, bus.out_valid, bus.out_sel, i % 4);
            end
        end
        drain(10);
    endtask

    task automatic test_lock();
        int n;
        logic [1:0] exp_sel [4];
        src_q[0].push_back({1'b1, 8'h05});
        drain(10);
        sel_log.delete();
        src_q[1].push_back({1'b0, 8'h11});
        src_q[1].push_back({1'b0, 8'h12});
        src_q[1].push_back({1'b1, 8'h13});
        src_q[0].push_back({1'b1, 8'h06});
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc[1] && n < 10);
        checks++;
        if (!acc[1]) begin
            errors++;
            $display("FAIL lock_first_accept got none exp ch1 accept");
        end
        src_en[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.in_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL lock_gap_ready0[%0d] got %b exp 0", i, bus.in_ready[0]);
            end
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lock_gap_bubble got v=%b exp 0", bus.out_valid);
        end
        src_en[1] = 1'b1;
        drain(20);
        exp_sel = '{2'd1, 2'd1, 2'd1, 2'd0};
        checks++;
        if (sel_log.size() != 4) begin
            errors++;
            $display("FAIL lock_count got %0d exp 4", sel_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (sel_log[i] !== exp_sel[i]) begin
                    errors++;
                    $display("FAIL lock_order[%0d] got %0d exp %0d", i, sel_log[i], exp_sel[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        want_ready = 1'b0;
        src_q[2].push_back({1'b1, 8'h31});
        src_q[2].push_back({1'b1, 8'h32});
        src_q[2].push_back({1'b1, 8'h33});
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h31 || bus.out_sel !== 2'd2 ||
                bus.out_last !== 1'b1 || bus.in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL stall_hold[%0d] got v=%b d=%h s=%0d l=%b rdy=%b exp v=1 d=31 s=2 l=1 rdy=0000",
                         i, bus.out_valid, bus.out_data, bus.out_sel, bus.out_last, bus.in_ready);
            end
        end
        want_ready = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 4'b0100 || bus.out_data !== 8'h31) begin
            errors++;
            $display("FAIL stall_release got rdy=%b d=%h exp rdy=0100 d=31", bus.in_ready, bus.out_data);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h32) begin
            errors++;
            $display("FAIL stall_b2b got v=%b d=%h exp v=1 d=32", bus.out_valid, bus.out_data);
        end
        drain(10);
    endtask

    task automatic test_async_reset();
        src_q[3].push_back({1'b0, 8'h41});
        src_q[3].push_back({1'b0, 8'h42});
        src_q[3].push_back({1'b0, 8'h43});
        src_q[3].push_back({1'b1, 8'h44});
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_sel !== 2'd0 ||
            bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got v=%b d=%h s=%0d l=%b exp all zero",
                     bus.out_valid, bus.out_data, bus.out_sel, bus.out_last);
        end
        clear_sources();
        model_reset();
        tick();
        tick();
        #1 rst_n = 1'b1;
        sel_log.delete();
        src_q[0].push_back({1'b1, 8'h50});
        src_q[3].push_back({1'b1, 8'h53});
        tick();
        checks++;
        if (bus.in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_grant got %b exp 0001", bus.in_ready);
        end
        drain(10);
        checks++;
        if (sel_log.size() != 2 || sel_log[0] !== 2'd0 || sel_log[1] !== 2'd3) begin
            errors++;
            $display("FAIL post_reset_order got n=%0d exp sel 0 then 3", sel_log.size());
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL idle[%0d] got v=%b rdy=%b exp v=0 rdy=0000", i, bus.out_valid, bus.in_ready);
            end
        end
        // last_grant should still be 3, so ch2 beats ch3.
        src_q[2].push_back({1'b1, 8'h62});
        src_q[3].push_back({1'b1, 8'h63});
        tick();
        checks++;
        if (bus.in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL idle_last_grant got %b exp 0100", bus.in_ready);
        end
        drain(10);
    endtask

    initial begin
        rst_n        = 1'b0;
        src_en       = '1;
        want_ready   = 1'b1;
        acc          = '0;
        bus.in_data  = '0;
        bus.in_valid = '0;
        bus.in_last  = '0;
        bus.out_ready = 1'b1;
        model_reset();

        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_stall();
        test_async_reset();
        test_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4_to_1_rr.md
Name: mux4_to_1_rr

Overview:
- 4-input to 1-output packet multiplexer with valid/ready handshaking. It is the merge-side counterpart of the 1-to-4 demultiplexer.
- Four source channels compete for one registered output. Arbitration is round-robin at packet granularity.
- The grant is held from a packet's first beat through its `last` beat, so packets never interleave.
- It sits where steered traffic is recombined ahead of a shared sink.

Parameters:
- DATA_W, 8, width of each data beat.

Ports:
- clk  input  1  single system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  4*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  4  per-channel beat valid.
- in_last  input  4  per-channel end-of-packet marker, qualified by in_valid.
- in_ready  output  4  per-channel accept, one-hot or zero.
- out_data  output  DATA_W  registered output beat.
- out_sel  output  2  index of the source channel of out_data.
- out_last  output  1  end-of-packet marker of the output beat.
- out_valid  output  1  output beat valid.
- out_ready  input  1  sink accept.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_sel=0, out_last=0.
  - state=IDLE, last_grant=3, so channel 0 has first priority.
- Output register:
  - load = !out_valid || out_ready.
  - A beat is accepted from channel g when load && grant_valid && grant==g. in_ready[g] = load && grant_valid && grant==g, combinational.
  - An accepted beat appears on out_* the next cycle with out_valid=1.
  - On a cycle where out_valid && out_ready and no beat is accepted, out_valid goes to 0.
  - out_data, out_sel and out_last hold while out_valid && !out_ready.
- Latency and throughput: 1 cycle from input accept to out_valid. 1 beat per cycle sustained while out_ready=1.
- State machine (2 states):
  - IDLE:
    - Search order is (last_grant+1)%4, +2, +3, last_grant.
    - grant = first channel in that order with in_valid=1.
    - grant_valid = |in_valid.
    - On accept: last_grant<=grant. If in_last[grant]=0, go to LOCKED with lock_idx<=grant. A single-beat packet stays in IDLE.
  - LOCKED:
    - grant=lock_idx and grant_valid=in_valid[lock_idx]. All other channels see in_ready=0.
    - On an accepted beat with in_last=1, go to IDLE.
    - If the locked source deasserts valid, bubbles are inserted and no other channel passes.
- Simultaneous events: the output draining (out_ready=1) and a new beat loading in the same cycle is a replace with no bubble.
- Boundary cases:
  - No requester: in_ready=0 and no state change.
  - All four requesting continuously: single-beat grants cycle 0,1,2,3,0.
  - Sink stalled (out_ready=0, out_valid=1): in_ready=0 for all channels and the arbiter does not advance.
- Reset mid-packet: the packet is aborted, state goes to IDLE, the output is emptied and last_grant=3. Upstream sources are responsible for re-framing.
- Protocol assumption: sources hold in_data and in_last stable while in_valid && !in_ready. The block does not check this.

Decomposition:
- Shared package/include holds:
  - NUM_CH=4 and SEL_W=2.
  - State encodings ST_IDLE=1'b0, ST_LOCKED=1'b1.
- One natural sub-module, rr_arbiter4:
  - Inputs: req[3:0], last_grant[1:0].
  - Outputs: grant[1:0], grant_valid.
  - Purely combinational rotating-priority search, reusable by other merge blocks.
- The top level holds the FSM, lock_idx, last_grant and the output register.

Test Plan:
- Reset, then only ch2 valid with in_data=0xA5 and last=1, out_ready=1 -> in_ready=4'b0100 that cycle; next cycle out_valid=1, out_data=0xA5, out_sel=2, out_last=1.
- All four channels valid with single-beat packets, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with no bubbles.
- ch1 sends a 3-beat packet (0x11, 0x12, 0x13 with last on the third) while ch0 is also valid:
  - out_sel=1 for three consecutive beats, then ch0 is served.
  - While ch1 drops valid mid-packet for 2 cycles, in_ready[0] stays 0 and out_valid=0 for those cycles.
- Output stall: out_valid=1 with out_ready=0 for 5 cycles -> out_data, out_sel and out_last stable and in_ready=0. When out_ready rises, the next beat loads the same cycle (back-to-back).
- Assert rst_n=0 asynchronously mid-packet on ch3 -> out_valid drops immediately. After release, ch0 and ch3 both valid -> ch0 is granted first, proving the lock is cleared and last_grant=3.
- Idle check: in_valid=0 for 10 cycles after traffic -> out_valid=0, in_ready=0, state IDLE and last_grant unchanged.
